icg_bank_ctrl: RTL

//  Multi-channel clock-gating controller with test override. Each of NCH

---
 rtl/icg_pkg.sv | 21 ++
 rtl/icg_cell.sv | 28 ++
 rtl/icg_bank_ctrl.sv | 137 +++++++++++++
 3 files changed

// File: rtl/icg_pkg.sv
// ============================================================================
// Module  : icg_pkg
// Brief   : Shared state encoding for the clock-gating bank controller.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package icg_pkg;

    localparam int C_STATE_W = 2;

    typedef enum logic [C_STATE_W-1:0] {
        ST_RUN   = 2'd0,
        ST_IDLE  = 2'd1,
        ST_GATED = 2'd2,
        ST_WAKE  = 2'd3
    } icg_state_t;

endpackage

`default_nettype wire

// File: rtl/icg_cell.sv
// ============================================================================
// Module  : icg_cell
// Brief   : Latch-based integrated clock gate (low-transparent latch + AND).
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module icg_cell (
    input  logic CK,
    input  logic E,
    input  logic SE,
    output logic GCK
);

    logic r_latch_q;

    // Latch only follows the enable while CK is low, so GCK cannot glitch.
    always_latch begin
        if (!CK) begin
            r_latch_q <= E | SE;
        end
    end

    assign GCK = CK & r_latch_q;

endmodule

`default_nettype wire

// File: rtl/icg_bank_ctrl.sv
// ============================================================================
// Module  : icg_bank_ctrl
// Brief   : Multi-channel idle-timeout clock-gating controller with scan
//           override. Optional per-channel gated-cycle statistics are built
//           when CLKGATE_STATS_EN is defined.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module icg_bank_ctrl
    import icg_pkg::*;
#(
    parameter int NCH      = 4,
    parameter int CNT_W    = 8,
    parameter int WAKE_CYC = 2
`ifdef CLKGATE_STATS_EN
    ,
    parameter int STAT_W   = 16
`endif
) (
    input  logic             CK,
    input  logic             RN,
    input  logic             SE,
    input  logic [NCH-1:0]   act,
    input  logic [NCH-1:0]   en_force,
    input  logic [CNT_W-1:0] idle_thresh,
    output logic [NCH-1:0]   gck,
    output logic [NCH-1:0]   rdy,
    output logic [NCH-1:0]   gated
`ifdef CLKGATE_STATS_EN
    ,
    input  logic                  stat_clr,
    output logic [NCH*STAT_W-1:0] stat_cnt
`endif
);

    localparam logic [CNT_W-1:0] C_CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] C_WAKE_LAST = CNT_W'(WAKE_CYC - 1);

    icg_state_t       r_state [NCH];
    logic [CNT_W-1:0] r_cnt   [NCH];
    logic [NCH-1:0]   r_en_q;
    logic [NCH-1:0]   r_rdy;
    logic [NCH-1:0]   r_gated;
    logic [NCH-1:0]   w_act;

    assign w_act = act | en_force;
    assign rdy   = r_rdy;
    assign gated = r_gated;

    always_ff @(posedge CK) begin
        for (int i = 0; i < NCH; i++) begin
            if (!RN) begin
                r_state[i] <= ST_RUN;
                r_cnt[i]   <= '0;
                r_en_q[i]  <= 1'b1;
                r_rdy[i]   <= 1'b1;
                r_gated[i] <= 1'b0;
            end else begin
                case (r_state[i])
                    ST_RUN: begin
                        if (w_act[i]) begin
                            r_cnt[i] <= '0;
                        end else begin
                            r_state[i] <= ST_IDLE;
                            r_cnt[i]   <= CNT_W'(1);
                        end
                    end
                    ST_IDLE: begin
                        if (w_act[i]) begin
                            r_state[i] <= ST_RUN;
                            r_cnt[i]   <= '0;
                        end else if ((idle_thresh != '0) && (r_cnt[i] >= idle_thresh)) begin
                            r_state[i] <= ST_GATED;
                            r_cnt[i]   <= '0;
                            r_en_q[i]  <= 1'b0;
                            r_rdy[i]   <= 1'b0;
                            r_gated[i] <= 1'b1;
                        end else if (r_cnt[i] != C_CNT_MAX) begin
                            r_cnt[i] <= r_cnt[i] + 1'b1;
                        end
                    end
                    ST_GATED: begin
                        if (w_act[i]) begin
                            r_state[i] <= ST_WAKE;
                            r_cnt[i]   <= '0;
                            r_en_q[i]  <= 1'b1;
                            r_gated[i] <= 1'b0;
                        end
                    end
                    ST_WAKE: begin
                        // Settle time runs to completion even if activity drops.
                        if (r_cnt[i] == C_WAKE_LAST) begin
                            r_state[i] <= ST_RUN;
                            r_cnt[i]   <= '0;
                            r_rdy[i]   <= 1'b1;
                        end else begin
                            r_cnt[i] <= r_cnt[i] + 1'b1;
                        end
                    end
                endcase
            end
        end
    end

    for (genvar g = 0; g < NCH; g++) begin : g_cell
        icg_cell u_icg_cell (
            .CK  (CK),
            .E   (r_en_q[g]),
            .SE  (SE),
            .GCK (gck[g])
        );
    end

`ifdef CLKGATE_STATS_EN
    localparam logic [STAT_W-1:0] C_STAT_MAX = '1;

    logic [STAT_W-1:0] r_stat [NCH];

    always_ff @(posedge CK) begin
        for (int i = 0; i < NCH; i++) begin
            if (!RN || stat_clr) begin
                r_stat[i] <= '0;
            end else if (r_gated[i] && (r_stat[i] != C_STAT_MAX)) begin
                r_stat[i] <= r_stat[i] + 1'b1;
            end
        end
    end

    for (genvar g = 0; g < NCH; g++) begin : g_stat
        assign stat_cnt[g*STAT_W +: STAT_W] = r_stat[g];
    end
`endif

endmodule

`default_nettype wire
